step_clock_ctrl: RTL

//  Parametrised clock-enable generator for stepping the CPU core. Debounces the step and mode keys.

---
 rtl/step_clock_ctrl_pkg.sv | 24 ++
 rtl/step_clock_ctrl_if.sv | 27 ++
 rtl/step_clock_ctrl_key_debounce.sv | 47 ++++
 rtl/step_clock_ctrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/step_clock_ctrl_pkg.sv
// Shared encodings for the step clock controller: operating modes and BURST sequencer states.
// The display/LED logic imports the same package so that the mode codes stay consistent.
package step_clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_BURST  = 2'b10
  } mode_e;

  typedef enum logic {
    BURST_IDLE = 1'b0,
    BURST_RUN  = 1'b1
  } burst_state_e;

  function automatic mode_e next_mode(mode_e cur);
    case (cur)
      MODE_MANUAL: next_mode = MODE_AUTO;
      MODE_AUTO:   next_mode = MODE_BURST;
      default:     next_mode = MODE_MANUAL;
    endcase
  endfunction

endpackage

// File: rtl/step_clock_ctrl_if.sv
// Key, control and step-enable signals between the board/core side and the step clock controller.
// The master drives keys and settings; the slave (the controller) drives the step enable and status.
interface step_clock_ctrl_if #(
  parameter int DIV_WIDTH   = 18,
  parameter int BURST_WIDTH = 8,
  parameter int CNT_WIDTH   = 16
);
  logic                   key_step;
  logic                   key_mode;
  logic                   halt;
  logic [DIV_WIDTH-1:0]   rate_div;
  logic [BURST_WIDTH-1:0] burst_len;
  logic                   step_pulse;
  logic [1:0]             mode;
  logic                   busy;
  logic [CNT_WIDTH-1:0]   step_count;

  modport master (
    output key_step, key_mode, halt, rate_div, burst_len,
    input  step_pulse, mode, busy, step_count
  );

  modport slave (
    input  key_step, key_mode, halt, rate_div, burst_len,
    output step_pulse, mode, busy, step_count
  );
endinterface

// File: rtl/step_clock_ctrl_key_debounce.sv
// Two-flop synchroniser, hold-time debouncer and rising-edge detector for one raw key.
// press is high for one cycle, the cycle after the debounced level rises.
module step_clock_ctrl_key_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] hold_cnt;

  // NOTE: non-blocking assignments keep the synchroniser a true two-stage shift register;
  // blocking ones would collapse sync1 and sync2 into a single flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      level    <= 1'b0;
      level_q  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      sync1   <= key;
      sync2   <= sync1;
      level_q <= level;
      if (sync2 == level) begin
        hold_cnt <= '0;
      end else if (hold_cnt == LAST) begin
        // DB_CYCLES consecutive differing samples, counting this one
        level    <= sync2;
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/step_clock_ctrl.sv
// Clock-enable generator that steps the CPU core in MANUAL, AUTO or BURST mode.
// Holds the mode register, the rate divider, the BURST sequencer and the pulse counter.
module step_clock_ctrl
  import step_clock_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH   = 18,
  parameter int DB_CYCLES   = 16,
  parameter int BURST_WIDTH = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic               clk,
  input  logic               reset,
  step_clock_ctrl_if.slave   bus
);

  logic step_press;
  logic mode_press;

  step_clock_ctrl_key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
    .clk   (clk),
    .reset (reset),
    .key   (bus.key_step),
    .press (step_press)
  );

  step_clock_ctrl_key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk   (clk),
    .reset (reset),
    .key   (bus.key_mode),
    .press (mode_press)
  );

  mode_e                  mode_q;
  burst_state_e           burst_state;
  logic [DIV_WIDTH-1:0]   div_cnt;
  logic [BURST_WIDTH-1:0] remaining;
  logic                   busy_q;
  logic                   pulse_q;
  logic [CNT_WIDTH-1:0]   count_q;
  logic                   tick;

  // >= rather than == so that lowering rate_div below the running count cannot stall the divider
  assign tick = (div_cnt >= bus.rate_div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q      <= MODE_MANUAL;
      burst_state <= BURST_IDLE;
      div_cnt     <= '0;
      remaining   <= '0;
      busy_q      <= 1'b0;
      pulse_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      pulse_q <= 1'b0;
      count_q <= count_q + CNT_WIDTH'(pulse_q);

      if (bus.halt) begin
        if (mode_q != MODE_MANUAL) begin
          mode_q      <= MODE_MANUAL;
          div_cnt     <= '0;
          burst_state <= BURST_IDLE;
          busy_q      <= 1'b0;
        end else begin
          pulse_q <= step_press;
        end
      end else if (mode_press) begin
        // AUTO is busy from the entry cycle so its first tick lands rate_div+1 cycles later
        mode_q      <= next_mode(mode_q);
        div_cnt     <= '0;
        burst_state <= BURST_IDLE;
        busy_q      <= (next_mode(mode_q) == MODE_AUTO);
      end else begin
        case (mode_q)
          MODE_MANUAL: pulse_q <= step_press;

          MODE_AUTO: begin
            busy_q  <= 1'b1;
            pulse_q <= tick;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
          end

          MODE_BURST: begin
            if (burst_state == BURST_IDLE) begin
              busy_q <= 1'b0;
              if (step_press) begin
                burst_state <= BURST_RUN;
                remaining   <= (bus.burst_len == '0) ? BURST_WIDTH'(1) : bus.burst_len;
                busy_q      <= 1'b1;
                div_cnt     <= '0;
              end
            end else if (tick) begin
              pulse_q   <= 1'b1;
              div_cnt   <= '0;
              remaining <= remaining - 1'b1;
              if (remaining == BURST_WIDTH'(1)) burst_state <= BURST_IDLE;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end

          default: mode_q <= MODE_MANUAL;
        endcase
      end
    end
  end

  assign bus.step_pulse = pulse_q;
  assign bus.mode       = mode_q;
  assign bus.busy       = busy_q;
  assign bus.step_count = count_q;

endmodule
